// File: rtl/p2s_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial stream converter.
package p2s_pkg;

    typedef enum logic {
        P2S_MSB_FIRST = 1'b0,
        P2S_LSB_FIRST = 1'b1
    } p2s_order_e;

    function automatic int p2s_beats(input int n, input int w);
        return n / w;
    endfunction

    // A one-beat word still needs a 1-bit counter so the port widths stay legal.
    function automatic int p2s_cnt_w(input int n, input int w);
        int b;
        b = n / w;
        return (b > 2) ? $clog2(b) : 1;
    endfunction

endpackage

// File: rtl/p2s_hold_reg.sv
// One-entry N-bit holding buffer with load/unload and a valid flag.
module p2s_hold_reg
    import p2s_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         unload,
    output logic         valid,
    output logic [N-1:0] data
);

    logic         valid_q, valid_d;
    logic [N-1:0] data_q, data_d;

    // Load wins over unload; the parent never requests both in one cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/p2s_stream_converter.sv
// Parallel-to-serial converter: N-bit words in, W-bit beats out, with a one-word
// holding buffer so consecutive words stream without bubbles.
module p2s_stream_converter
    import p2s_pkg::*;
#(
    parameter int N         = 8,
    parameter int W         = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         par_valid,
    input  logic [N-1:0] par_data,
    output logic         par_ready,
    input  logic         ser_ready,
    output logic         ser_valid,
    output logic [W-1:0] ser_data,
    output logic         ser_last
);

    localparam int                 BEATS    = p2s_beats(N, W);
    localparam int                 CNT_W    = p2s_cnt_w(N, W);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BEATS - 1);
    localparam p2s_order_e         ORDER    = (LSB_FIRST != 0) ? P2S_LSB_FIRST : P2S_MSB_FIRST;

    logic [N-1:0]     sh_q, sh_d;
    logic             sh_valid_q, sh_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             hd_valid;
    logic [N-1:0]     hd_data;
    logic             hd_load;
    logic             hd_unload;

    logic             acc;
    logic             fire;
    logic             at_last;
    logic             done;

    p2s_hold_reg #(.N(N)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (hd_load),
        .load_data (par_data),
        .unload    (hd_unload),
        .valid     (hd_valid),
        .data      (hd_data)
    );

    assign par_ready = !hd_valid;
    assign acc       = par_valid & par_ready;
    assign fire      = sh_valid_q & ser_ready;
    assign at_last   = (cnt_q == LAST_CNT);
    assign done      = fire & at_last;

    // Shifter/counter control; a finishing word hands over to the held word
    // first, otherwise straight to an incoming word for zero-bubble streaming.
    always_comb begin
        sh_d       = sh_q;
        sh_valid_d = sh_valid_q;
        cnt_d      = cnt_q;
        hd_load    = 1'b0;
        hd_unload  = 1'b0;
        if (!sh_valid_q) begin
            if (acc) begin
                sh_d       = par_data;
                sh_valid_d = 1'b1;
                cnt_d      = '0;
            end
        end else if (done) begin
            cnt_d = '0;
            if (hd_valid) begin
                sh_d      = hd_data;
                hd_unload = 1'b1;
            end else if (acc) begin
                sh_d = par_data;
            end else begin
                sh_valid_d = 1'b0;
            end
        end else if (fire) begin
            sh_d    = (ORDER == P2S_LSB_FIRST) ? (sh_q >> W) : (sh_q << W);
            cnt_d   = cnt_q + CNT_W'(1);
            hd_load = acc;
        end else begin
            hd_load = acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q       <= '0;
            sh_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sh_q       <= sh_d;
            sh_valid_q <= sh_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ser_valid = sh_valid_q;
    assign ser_last  = sh_valid_q & at_last;
    assign ser_data  = (ORDER == P2S_LSB_FIRST) ? sh_q[W-1:0] : sh_q[N-1 -: W];

endmodule
